// File: rtl/irq_pkg.sv
// irq_pkg: shared constants, FSM encoding and pointer wrap rule for irq_controller_18
package irq_pkg;
    localparam int NUM_SOURCES = 18;
    localparam int ID_WIDTH = 5;
    localparam logic [ID_WIDTH-1:0] LAST_ID = 5'd17;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_e;
    function automatic logic [ID_WIDTH-1:0] next_rr(input logic [ID_WIDTH-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction
endpackage

// File: rtl/irq_controller_18_if.sv
// irq_controller_18_if: request/enable inputs and CPU handshake of the interrupt controller
interface irq_controller_18_if;
    import irq_pkg::*;
    logic [NUM_SOURCES-1:0] Requests;
    logic [NUM_SOURCES-1:0] EnableMask;
    logic                   IrqAck;
    logic                   IrqDone;
    logic                   IrqOut;
    logic [ID_WIDTH-1:0]    IrqId;
    logic                   AnyPending;
    logic                   Busy;
    modport master(output Requests, EnableMask, IrqAck, IrqDone, input IrqOut, IrqId, AnyPending, Busy);
    modport slave(input Requests, EnableMask, IrqAck, IrqDone, output IrqOut, IrqId, AnyPending, Busy);
endinterface

// File: rtl/rr_priority_picker_18.sv
// rr_priority_picker_18: first set bit of masked scanning upward from rr with wrap 17 -> 0
module rr_priority_picker_18
    import irq_pkg::*;
(
    input  logic [NUM_SOURCES-1:0] masked_i,
    input  logic [ID_WIDTH-1:0]    rr_i,
    output logic                   found_o,
    output logic [ID_WIDTH-1:0]    winner_o
);
    logic [NUM_SOURCES-1:0] rot;
    logic [ID_WIDTH-1:0]    off;
    logic [ID_WIDTH:0]      sum;
    // bit j of rot is source (j + rr) mod 18, so the lowest set bit is the nearest winner
    assign rot = NUM_SOURCES'({masked_i, masked_i} >> rr_i);
    always_comb begin
        off = '0;
        for (int j = NUM_SOURCES - 1; j >= 0; j--)
            if (rot[j]) off = ID_WIDTH'(j);
    end
    assign found_o  = |masked_i;
    assign sum      = {1'b0, off} + {1'b0, rr_i};
    assign winner_o = (sum >= (ID_WIDTH+1)'(NUM_SOURCES)) ? ID_WIDTH'(sum - (ID_WIDTH+1)'(NUM_SOURCES)) : sum[ID_WIDTH-1:0];
endmodule

// File: rtl/irq_controller_18.sv
// irq_controller_18: edge-captured pending sources sequenced to the CPU over IrqOut/IrqAck/IrqDone
module irq_controller_18
    import irq_pkg::*;
#(
    parameter logic [NUM_SOURCES-1:0] InvertMask = '0,
    parameter bit                     RoundRobin = 1'b1
) (
    input logic                Clock,
    input logic                Reset,
    irq_controller_18_if.slave bus
);
    state_e                 state_q;
    logic [NUM_SOURCES-1:0] prev_q, pending_q, pending_d, real_lvl, masked, clr;
    logic [ID_WIDTH-1:0]    rr_q, id_q, winner;
    logic                   irq_q, busy_q, found;
    assign real_lvl  = bus.Requests ^ InvertMask;
    assign masked    = pending_q & bus.EnableMask;
    assign clr       = (state_q == REQ && bus.IrqAck) ? NUM_SOURCES'(1) << id_q : '0;
    // a new event wins over the ack clear in the same cycle
    assign pending_d = (pending_q & ~clr) | (real_lvl & ~prev_q);
    rr_priority_picker_18 u_picker (
        .masked_i(masked),
        .rr_i    (rr_q),
        .found_o (found),
        .winner_o(winner)
    );
    always_ff @(posedge Clock) begin
        prev_q <= real_lvl;
        if (Reset) begin
            pending_q <= '0;
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            id_q      <= '0;
            rr_q      <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: if (found) begin
                    id_q    <= winner;
                    irq_q   <= 1'b1;
                    state_q <= REQ;
                end
                REQ: if (bus.IrqAck) begin
                    irq_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= SERVICE;
                end else if (!bus.EnableMask[id_q]) begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
                SERVICE: if (bus.IrqDone) begin
                    busy_q  <= 1'b0;
                    rr_q    <= RoundRobin ? next_rr(id_q) : '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.IrqOut     = irq_q;
    assign bus.IrqId      = id_q;
    assign bus.Busy       = busy_q;
    assign bus.AnyPending = |masked;
endmodule

// File: tb/tb_irq_controller_18.sv
// tb_irq_controller_18: directed bench with a queue of expected grant IDs for irq_controller_18
module tb_irq_controller_18;
    import irq_pkg::*;
    localparam logic [NUM_SOURCES-1:0] IDLE_REQ = 18'h00001;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_q[$];
    irq_controller_18_if bus();
    irq_controller_18 #(.InvertMask(18'h00001), .RoundRobin(1'b1)) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus.slave)
    );
    always #5 clk = ~clk;
    function automatic logic [NUM_SOURCES-1:0] bitm(input int i);
        return NUM_SOURCES'(1) << i;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic pulse(input logic [NUM_SOURCES-1:0] m);
        bus.Requests = IDLE_REQ ^ m;
        tick();
        bus.Requests = IDLE_REQ;
    endtask
    task automatic expect_grant();
        int k = 0;
        int e;
        while (!bus.IrqOut && k < 20) begin
            tick();
            k++;
        end
        chk("irqout_wait", 32'(bus.IrqOut), 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        chk("grant_id", 32'(bus.IrqId), e);
    endtask
    task automatic ack();
        bus.IrqAck = 1'b1;
        tick();
        bus.IrqAck = 1'b0;
        chk("ack_irqout", 32'(bus.IrqOut), 0);
        chk("ack_busy", 32'(bus.Busy), 1);
    endtask
    task automatic done();
        bus.IrqDone = 1'b1;
        tick();
        bus.IrqDone = 1'b0;
        chk("done_busy", 32'(bus.Busy), 0);
    endtask
    task automatic serve(input logic [NUM_SOURCES-1:0] svc_pulse);
        expect_grant();
        ack();
        if (svc_pulse != '0) pulse(svc_pulse);
        done();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask
    initial begin
        bus.Requests   = '1;
        bus.EnableMask = '1;
        bus.IrqAck     = 1'b0;
        bus.IrqDone    = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_irqout", 32'(bus.IrqOut), 0);
            chk("rst_anypend", 32'(bus.AnyPending), 0);
            chk("rst_irqid", 32'(bus.IrqId), 0);
        end
        bus.Requests = IDLE_REQ;
        tick();
        tick();
        chk("release_anypend", 32'(bus.AnyPending), 0);
        // single source: exact two-edge latency
        exp_q.push_back(5);
        bus.Requests = IDLE_REQ ^ bitm(5);
        tick();
        bus.Requests = IDLE_REQ;
        chk("lat_k_irqout", 32'(bus.IrqOut), 0);
        chk("lat_k_anypend", 32'(bus.AnyPending), 1);
        tick();
        chk("lat_k1_irqout", 32'(bus.IrqOut), 1);
        expect_grant();
        ack();
        done();
        // rr is now 6, so 7 beats 5
        exp_q.push_back(7);
        exp_q.push_back(5);
        pulse(bitm(5) | bitm(7));
        serve('0);
        serve('0);
        // simultaneous 3,10,17 from rr=0, new edge on 3 while 10 is serviced
        do_reset();
        exp_q.push_back(3);
        exp_q.push_back(10);
        exp_q.push_back(17);
        exp_q.push_back(3);
        pulse(bitm(3) | bitm(10) | bitm(17));
        serve('0);
        serve(bitm(3));
        serve('0);
        serve('0);
        // active-low source 0: falling edge grants, rising edge is ignored
        exp_q.push_back(0);
        pulse(bitm(0));
        serve('0);
        tick();
        tick();
        chk("inv_rise_anypend", 32'(bus.AnyPending), 0);
        chk("inv_rise_irqout", 32'(bus.IrqOut), 0);
        // enable withdrawal in REQ
        exp_q.push_back(7);
        pulse(bitm(7));
        tick();
        chk("wd_irqout", 32'(bus.IrqOut), 1);
        chk("wd_irqid", 32'(bus.IrqId), 7);
        bus.EnableMask = ~bitm(7);
        #1;
        chk("wd_anypend_comb", 32'(bus.AnyPending), 0);
        tick();
        chk("wd_irqout_drop", 32'(bus.IrqOut), 0);
        tick();
        chk("wd_irqout_idle", 32'(bus.IrqOut), 0);
        bus.EnableMask = '1;
        #1;
        chk("wd_anypend_back", 32'(bus.AnyPending), 1);
        tick();
        chk("wd_irqout_again", 32'(bus.IrqOut), 1);
        serve('0);
        // event coinciding with its own ack keeps pending
        exp_q.push_back(4);
        exp_q.push_back(4);
        pulse(bitm(4));
        expect_grant();
        bus.IrqAck   = 1'b1;
        bus.Requests = IDLE_REQ ^ bitm(4);
        tick();
        bus.IrqAck   = 1'b0;
        bus.Requests = IDLE_REQ;
        chk("setwin_irqout", 32'(bus.IrqOut), 0);
        chk("setwin_busy", 32'(bus.Busy), 1);
        chk("setwin_anypend", 32'(bus.AnyPending), 1);
        done();
        expect_grant();
        ack();
        pulse(bitm(9));
        chk("svc_anypend", 32'(bus.AnyPending), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_irqout", 32'(bus.IrqOut), 0);
        chk("midrst_busy", 32'(bus.Busy), 0);
        chk("midrst_irqid", 32'(bus.IrqId), 0);
        chk("midrst_anypend", 32'(bus.AnyPending), 0);
        tick();
        tick();
        chk("post_rst_irqout", 32'(bus.IrqOut), 0);
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
